fp_addsub: RTL

FP_ADDSUB -- requirements
Module: fp_addsub

---
 rtl/fp_addsub_if.sv | 34 +++
 rtl/fp_addsub.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_if.sv
// fp_addsub_if: operand/result handshake bundle for fp_addsub.
// Signals:
//   in_valid/in_ready  - operand pair (a, b, op_sub) handshake
//   out_valid/out_ready - result (result, zero, ovf) handshake
// Modports:
//   master - producer of operands / consumer of results
//   slave  - the adder itself
interface fp_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;

    modport master (
        output in_valid, a, b, op_sub, out_ready,
        input  in_ready, out_valid, result, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, op_sub, out_ready,
        output in_ready, out_valid, result, zero, ovf
    );
endinterface

// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle floating-point adder/subtractor
// (IDLE -> ALIGN -> ADD -> NORM -> DONE), one operation in flight.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; aborts any operation
//   bus   - fp_addsub_if.slave: in_valid/in_ready, a, b, op_sub,
//           out_valid/out_ready, result, zero, ovf
// Option macro FP_ADDSUB_ROUND_EN: round to nearest even in NORM;
// when undefined the result is truncated (round toward zero).
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        reset,
    fp_addsub_if.slave  bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    // carry | hidden | fraction | guard | round | sticky
    localparam int SW   = MAN_W + 5;
    // exponent with headroom for carry/round and a sign bit
    localparam int XW   = EXP_W + 2;
    localparam int LW   = $clog2(SW) + 1;
    localparam int EMAX = (1 << EXP_W) - 1;
`ifdef FP_ADDSUB_ROUND_EN
    localparam int MW   = MAN_W + 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [SW-1:0]    big_q, big_d;
    logic [SW-1:0]    small_q, small_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sign_q, sign_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    // ---------------- align datapath ----------------
    logic [EXP_W-1:0] ea, eb, el, es, diff;
    logic [MAN_W-1:0] fa, fb;
    logic             a_ge_b;
    logic [SW-1:0]    sig_l, sig_s, sig_sh, mask;
    logic             al_sign;

    always_comb begin
        ea = a_q[W-2 -: EXP_W];
        eb = b_q[W-2 -: EXP_W];
        // zero exponent flushes the whole operand to zero
        fa = (ea == '0) ? '0 : a_q[MAN_W-1:0];
        fb = (eb == '0) ? '0 : b_q[MAN_W-1:0];
        a_ge_b = {ea, fa} >= {eb, fb};
        el = a_ge_b ? ea : eb;
        es = a_ge_b ? eb : ea;
        sig_l = {1'b0, el != '0, a_ge_b ? fa : fb, 3'b000};
        sig_s = {1'b0, es != '0, a_ge_b ? fb : fa, 3'b000};
        diff = el - es;
        mask = ~({SW{1'b1}} << diff);
        if (int'(diff) > MAN_W + 3) begin
            sig_sh = {{(SW-1){1'b0}}, |sig_s};
        end else begin
            sig_sh = sig_s >> diff;
            // bits shifted out collapse into the sticky position
            sig_sh[0] = sig_sh[0] | (|(sig_s & mask));
        end
        al_sign = a_ge_b ? a_q[W-1] : b_q[W-1];
    end

    // ---------------- normalise / round ----------------
    logic [LW-1:0]    lzc;
    logic             found;
    logic [SW-1:0]    norm;
    logic [XW-1:0]    xp, xr;
    logic [MAN_W-1:0] frac;
    logic             nm_zero, nm_ovf;
    logic [W-1:0]     nm_result;
    logic             nm_unused;
`ifdef FP_ADDSUB_ROUND_EN
    logic             rnd_up;
    logic [MW-1:0]    man_r;
`endif

    always_comb begin
        lzc   = LW'(SW - 1);
        found = 1'b0;
        for (int i = SW - 2; i >= 0; i--) begin
            if (!found && sum_q[i]) begin
                lzc   = LW'(SW - 2 - i);
                found = 1'b1;
            end
        end
        if (sum_q[SW-1]) begin
            norm = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            xp   = {2'b00, exp_q} + XW'(1);
        end else begin
            norm = sum_q << lzc;
            xp   = {2'b00, exp_q} - XW'(lzc);
        end
`ifdef FP_ADDSUB_ROUND_EN
        // nearest-even: up when guard set and (round|sticky|lsb)
        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r  = {1'b0, norm[SW-2:3]} + MW'(rnd_up);
        if (man_r[MAN_W+1]) begin
            frac = man_r[MAN_W:1];
            xr   = xp + XW'(1);
        end else begin
            frac = man_r[MAN_W-1:0];
            xr   = xp;
        end
        nm_unused = norm[SW-1];
`else
        frac      = norm[MAN_W+2:3];
        xr        = xp;
        nm_unused = ^{norm[SW-1:SW-2], norm[2:0]};
`endif
        nm_zero = (sum_q == '0) || xp[XW-1] || (xp == '0);
        nm_ovf  = !nm_zero && (xr >= XW'(EMAX));
        if (nm_zero) begin
            nm_result = '0;
        end else if (nm_ovf) begin
            nm_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            nm_result = {sign_q, xr[EXP_W-1:0], frac};
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        big_d       = big_q;
        small_d     = small_q;
        sum_d       = sum_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = {bus.b[W-1] ^ bus.op_sub, bus.b[W-2:0]};
                    in_ready_d = 1'b0;
                    state_d    = S_ALIGN;
                end
            end
            S_ALIGN: begin
                big_d   = sig_l;
                small_d = sig_sh;
                exp_d   = el;
                sign_d  = al_sign;
                sub_d   = a_q[W-1] ^ b_q[W-1];
                state_d = S_ADD;
            end
            S_ADD: begin
                sum_d   = sub_q ? big_q - small_q : big_q + small_q;
                state_d = S_NORM;
            end
            S_NORM: begin
                result_d    = nm_result;
                zero_d      = nm_zero;
                ovf_d       = nm_ovf;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            big_q       <= '0;
            small_q     <= '0;
            sum_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            big_q       <= big_d;
            small_q     <= small_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
endmodule
